// File: rtl/result_checker_pkg.sv
// Shared types for the result checker: controller states and compare-mode encodings.
package result_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MODE_LAST  = 1'b0;
    localparam logic MODE_FIRST = 1'b1;

endpackage

// File: rtl/result_chan.sv
// One watched channel: latched address/expect/enable, write capture, seen flag and verdict.
module result_chan
    import result_checker_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              ph2,
    input  logic              resetb,
    input  logic              i_load,
    input  logic              i_run,
    input  logic              i_eval,
    input  logic              i_mode,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_expect,
    input  logic              i_mem_we,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic              o_en,
    output logic              o_seen,
    output logic              o_seen_next,
    output logic [DATA_W-1:0] o_data,
    output logic              o_fail_next,
    output logic              o_fail
);

    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_expect;
    logic [DATA_W-1:0] r_data;
    logic              r_seen;
    logic              r_fail;

    logic w_hit;
    logic w_cap;

    assign w_hit = i_run & r_en & i_mem_we & (i_mem_addr == r_addr);
    // FIRST mode freezes the capture once the channel has been seen
    assign w_cap = w_hit & ((i_mode == MODE_LAST) | ~r_seen);

    always_ff @(posedge ph2) begin
        if (!resetb) begin
            r_en     <= 1'b0;
            r_addr   <= '0;
            r_expect <= '0;
            r_data   <= '0;
            r_seen   <= 1'b0;
            r_fail   <= 1'b0;
        end else if (i_load) begin
            r_en     <= i_en;
            r_addr   <= i_addr;
            r_expect <= i_expect;
            r_data   <= '0;
            r_seen   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            if (w_cap) begin
                r_data <= i_mem_wdata;
                r_seen <= 1'b1;
            end
            if (i_eval) begin
                r_fail <= o_fail_next;
            end
        end
    end

    assign o_en        = r_en;
    assign o_seen      = r_seen;
    assign o_seen_next = r_seen | w_hit;
    assign o_data      = r_data;
    assign o_fail_next = r_en & (~r_seen | (r_data != r_expect));
    assign o_fail      = r_fail;

endmodule

// File: rtl/result_checker.sv
// Self-test monitor: snoops CPU writes to NCHAN watched addresses and judges them
// against expected bytes after a cycle timeout or, in FIRST mode, once all are seen.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   ST_IDLE | after reset, waiting for start
//   ST_RUN  | counting cycles and capturing watched writes
//   ST_EVAL | one cycle computing fail_mask and pass
//   ST_DONE | results held until the next start or reset
module result_checker
    import result_checker_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NCHAN  = 4,
    parameter int TMO_W  = 16
) (
    input  logic                    ph2,
    input  logic                    resetb,
    input  logic                    start,
    input  logic                    mode,
    input  logic [TMO_W-1:0]        timeout_cycles,
    input  logic [NCHAN-1:0]        chk_en,
    input  logic [NCHAN*ADDR_W-1:0] chk_addr,
    input  logic [NCHAN*DATA_W-1:0] chk_expect,
    input  logic                    mem_we,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [NCHAN-1:0]        fail_mask,
    output logic [NCHAN-1:0]        seen_mask,
    output logic [NCHAN*DATA_W-1:0] last_data,
    output logic [TMO_W-1:0]        cycles
);

    localparam logic [TMO_W-1:0] CYC_ONE = TMO_W'(1);

    state_t           r_state;
    logic             r_mode;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] r_cycles;
    logic             r_pass;

    logic                    w_load;
    logic                    w_run;
    logic                    w_eval;
    logic                    w_all_seen;
    logic                    w_exit;
    logic [TMO_W-1:0]        w_cyc_inc;
    logic [NCHAN-1:0]        w_en;
    logic [NCHAN-1:0]        w_seen;
    logic [NCHAN-1:0]        w_seen_next;
    logic [NCHAN-1:0]        w_fail_next;
    logic [NCHAN-1:0]        w_fail;
    logic [NCHAN*DATA_W-1:0] w_data;

    assign w_load = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_run  = (r_state == ST_RUN);
    assign w_eval = (r_state == ST_EVAL);

    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
        result_chan #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_chan (
            .ph2         (ph2),
            .resetb      (resetb),
            .i_load      (w_load),
            .i_run       (w_run),
            .i_eval      (w_eval),
            .i_mode      (r_mode),
            .i_en        (chk_en[gi]),
            .i_addr      (chk_addr[gi*ADDR_W +: ADDR_W]),
            .i_expect    (chk_expect[gi*DATA_W +: DATA_W]),
            .i_mem_we    (mem_we),
            .i_mem_addr  (mem_addr),
            .i_mem_wdata (mem_wdata),
            .o_en        (w_en[gi]),
            .o_seen      (w_seen[gi]),
            .o_seen_next (w_seen_next[gi]),
            .o_data      (w_data[gi*DATA_W +: DATA_W]),
            .o_fail_next (w_fail_next[gi]),
            .o_fail      (w_fail[gi])
        );
    end

    // Saturating increment; the timeout compare fires before the counter could wrap
    assign w_cyc_inc  = (&r_cycles) ? r_cycles : r_cycles + CYC_ONE;
    // Disabled channels count as seen, so an all-disabled FIRST run ends on its first edge
    assign w_all_seen = &(w_seen_next | ~w_en);
    assign w_exit     = (w_cyc_inc == r_tmo) | ((r_mode == MODE_FIRST) & w_all_seen);

    always_ff @(posedge ph2) begin
        if (!resetb) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_LAST;
            r_tmo    <= '0;
            r_cycles <= '0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_mode   <= mode;
                        r_tmo    <= (timeout_cycles == '0) ? CYC_ONE : timeout_cycles;
                        r_cycles <= '0;
                        r_pass   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_cycles <= w_cyc_inc;
                    if (w_exit) begin
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    r_pass  <= ~|w_fail_next;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = w_run | w_eval;
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign fail_mask = w_fail;
    assign seen_mask = w_seen;
    assign last_data = w_data;
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: a whole-run reference model predicts the exit cycle and a
// per-cycle capture trace; one compare process checks every output on every cycle.
module tb_result_checker;

    localparam int NCH  = 4;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int TW   = 16;
    localparam int MAXK = 1024;

    logic              ph2 = 1'b0;
    logic              resetb = 1'b0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [TW-1:0]     timeout_cycles = '0;
    logic [NCH-1:0]    chk_en = '0;
    logic [NCH*AW-1:0] chk_addr = '0;
    logic [NCH*DW-1:0] chk_expect = '0;
    logic              mem_we = 1'b0;
    logic [AW-1:0]     mem_addr = '0;
    logic [DW-1:0]     mem_wdata = '0;
    logic              busy, done, pass;
    logic [NCH-1:0]    fail_mask, seen_mask;
    logic [NCH*DW-1:0] last_data;
    logic [TW-1:0]     cycles;

    result_checker #(.ADDR_W(AW), .DATA_W(DW), .NCHAN(NCH), .TMO_W(TW)) dut (
        .ph2(ph2), .resetb(resetb), .start(start), .mode(mode),
        .timeout_cycles(timeout_cycles), .chk_en(chk_en), .chk_addr(chk_addr),
        .chk_expect(chk_expect), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .seen_mask(seen_mask), .last_data(last_data),
        .cycles(cycles)
    );

    always #5 ph2 = ~ph2;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Write schedule indexed by RUN edge number (write driven so it is sampled at edge k)
    logic          sc_we   [MAXK];
    logic [AW-1:0] sc_addr [MAXK];
    logic [DW-1:0] sc_data [MAXK];

    // Reference model: configuration, predicted exit edge, verdict and capture trace
    logic          m_mode;
    logic [TW-1:0] m_tmo;
    logic [NCH-1:0] m_en;
    logic [AW-1:0] m_addr [NCH];
    logic [DW-1:0] m_exp  [NCH];
    int            m_x;
    logic          m_pass;
    logic [NCH-1:0] m_fail;
    logic [NCH-1:0]    snap_seen [MAXK];
    logic [NCH*DW-1:0] snap_data [MAXK];

    task automatic clear_sched();
        for (int k = 0; k < MAXK; k++) begin
            sc_we[k]   = 1'b0;
            sc_addr[k] = AW'($urandom);
            sc_data[k] = DW'($urandom);
        end
    endtask

    task automatic add_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sc_we[k]   = 1'b1;
        sc_addr[k] = a;
        sc_data[k] = d;
    endtask

    task automatic model();
        int t;
        logic [NCH-1:0] seen;
        logic [DW-1:0]  d [NCH];
        t = (m_tmo == 0) ? 1 : int'(m_tmo);
        seen = '0;
        for (int i = 0; i < NCH; i++) d[i] = '0;
        snap_seen[0] = '0;
        snap_data[0] = '0;
        m_x = t;
        for (int k = 1; k <= t; k++) begin
            if (sc_we[k]) begin
                for (int i = 0; i < NCH; i++) begin
                    if (m_en[i] && sc_addr[k] == m_addr[i] && (m_mode == 1'b0 || !seen[i])) begin
                        d[i]    = sc_data[k];
                        seen[i] = 1'b1;
                    end
                end
            end
            snap_seen[k] = seen;
            for (int i = 0; i < NCH; i++) snap_data[k][i*DW +: DW] = d[i];
            if (m_mode == 1'b1 && ((seen & m_en) == m_en)) begin
                m_x = k;
                break;
            end
        end
        for (int i = 0; i < NCH; i++)
            m_fail[i] = m_en[i] && (!seen[i] || d[i] != m_exp[i]);
        m_pass = (m_fail == '0);
    endtask

    // Compare process: cmp_k = edges since accepted start, -1 idle/reset, -2 done
    int   cmp_k = -1;
    logic armed = 1'b0;

    always @(posedge ph2) begin
        logic s_start, s_rst;
        s_start = start;
        s_rst   = resetb;
        #1;
        if (!s_rst) begin
            armed = 1'b1;
            cmp_k = -1;
        end else if (armed) begin
            if (s_start && cmp_k < 0) cmp_k = 0;
            else if (cmp_k >= 0) begin
                cmp_k++;
                if (cmp_k > m_x) cmp_k = -2;
            end
        end
        if (armed) begin
            if (cmp_k == -1) begin
                check("busy", busy, 0);
                check("done", done, 0);
                check("pass", pass, 0);
                check("fail_mask", fail_mask, 0);
                check("seen_mask", seen_mask, 0);
                check("last_data", last_data, 0);
                check("cycles", cycles, 0);
            end else if (cmp_k == -2) begin
                check("busy", busy, 0);
                check("done", done, 1);
                check("pass", pass, m_pass);
                check("fail_mask", fail_mask, m_fail);
                check("seen_mask", seen_mask, snap_seen[m_x]);
                check("last_data", last_data, snap_data[m_x]);
                check("cycles", cycles, m_x);
            end else begin
                check("busy", busy, 1);
                check("done", done, 0);
                check("pass", pass, 0);
                check("fail_mask", fail_mask, 0);
                check("seen_mask", seen_mask, snap_seen[cmp_k]);
                check("last_data", last_data, snap_data[cmp_k]);
                check("cycles", cycles, cmp_k);
            end
        end
    end

    // Runs one check; rst_k>0 aborts with reset at that RUN edge, ign_k>0 pulses start mid-run
    task automatic run_check(input logic md, input logic [TW-1:0] tmo, input logic [NCH-1:0] en,
                             input logic [NCH*AW-1:0] ad, input logic [NCH*DW-1:0] ex,
                             input int rst_k, input int ign_k);
        m_mode = md;
        m_tmo  = tmo;
        m_en   = en;
        for (int i = 0; i < NCH; i++) begin
            m_addr[i] = ad[i*AW +: AW];
            m_exp[i]  = ex[i*DW +: DW];
        end
        model();
        mode = md; timeout_cycles = tmo; chk_en = en; chk_addr = ad; chk_expect = ex;
        mem_we = 1'b0;
        start = 1'b1;
        @(negedge ph2);
        start = 1'b0;
        // Configuration must already be latched, so scramble the inputs
        mode = 1'($urandom); timeout_cycles = TW'($urandom); chk_en = NCH'($urandom);
        chk_addr = {$urandom, $urandom}; chk_expect = $urandom;
        for (int k = 1; k <= m_x + 2; k++) begin
            if (k <= m_x) begin
                mem_we = sc_we[k]; mem_addr = sc_addr[k]; mem_wdata = sc_data[k];
            end else begin
                mem_we = 1'b1; mem_addr = m_addr[k % NCH]; mem_wdata = DW'($urandom);
            end
            start = (k == ign_k);
            if (k == rst_k) resetb = 1'b0;
            @(negedge ph2);
            start = 1'b0;
            if (k == rst_k) begin
                resetb = 1'b1;
                break;
            end
        end
        mem_we = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 5000000", $time);
        $fatal(1);
    end

    initial begin
        logic [NCH*AW-1:0] ad;
        logic [NCH*DW-1:0] ex;
        logic [AW-1:0] pool [3];
        logic [DW-1:0] vals [4];

        clear_sched();
        repeat (3) @(negedge ph2);
        resetb = 1'b1;
        repeat (2) @(negedge ph2);

        // Flag-test: 0xCE written to 0x0030 at cycle 10, T=215
        ad = {16'h0, 16'h0, 16'h0, 16'h0030};
        ex = {8'h0, 8'h0, 8'h0, 8'hCE};
        clear_sched(); add_wr(10, 16'h0030, 8'hCE);
        run_check(1'b0, 16'd215, 4'b0001, ad, ex, 0, 0);
        check("flag_model_exit", m_x, 215);
        check("flag_done", done, 1);
        check("flag_pass", pass, 1);
        check("flag_fail", fail_mask, 4'b0000);
        check("flag_cycles", cycles, 215);

        // Wrong value
        clear_sched(); add_wr(10, 16'h0030, 8'hCF);
        run_check(1'b0, 16'd215, 4'b0001, ad, ex, 0, 0);
        check("wrong_pass", pass, 0);
        check("wrong_fail", fail_mask, 4'b0001);
        check("wrong_data", last_data[7:0], 8'hCF);

        // Overwrite semantics, LAST then FIRST
        clear_sched(); add_wr(5, 16'h0030, 8'h11); add_wr(8, 16'h0030, 8'hCE);
        run_check(1'b0, 16'd40, 4'b0001, ad, ex, 0, 0);
        check("ovw_last_pass", pass, 1);
        check("ovw_last_data", last_data[7:0], 8'hCE);
        run_check(1'b1, 16'd40, 4'b0001, ad, ex, 0, 0);
        check("ovw_first_fail", fail_mask, 4'b0001);
        check("ovw_first_data", last_data[7:0], 8'h11);

        // FIRST mode early finish
        ad = {16'h0, 16'h0, 16'h0031, 16'h0030};
        ex = {8'h0, 8'h0, 8'h55, 8'hAA};
        clear_sched(); add_wr(5, 16'h0030, 8'hAA); add_wr(9, 16'h0031, 8'h55);
        run_check(1'b1, 16'd1000, 4'b0011, ad, ex, 0, 0);
        check("early_cycles", cycles, 9);
        check("early_pass", pass, 1);

        // Channel 2 enabled but never written
        ad = {16'h0, 16'h0040, 16'h0031, 16'h0030};
        ex = {8'h0, 8'h77, 8'h55, 8'hAA};
        run_check(1'b0, 16'd50, 4'b0111, ad, ex, 0, 0);
        check("miss_fail", fail_mask, 4'b0100);
        check("miss_seen", seen_mask, 4'b0011);

        // timeout_cycles = 0 behaves as 1
        clear_sched();
        run_check(1'b0, 16'd0, 4'b0001, ad, ex, 0, 0);
        check("tmo0_cycles", cycles, 1);
        check("tmo0_fail", fail_mask, 4'b0001);

        // All channels disabled in FIRST mode
        run_check(1'b1, 16'd100, 4'b0000, ad, ex, 0, 0);
        check("noen_cycles", cycles, 1);
        check("noen_pass", pass, 1);

        // Reset mid-run with an ignored start pulse, then a clean check
        ad = {16'h0, 16'h0, 16'h0, 16'h0030};
        ex = {8'h0, 8'h0, 8'h0, 8'hCE};
        clear_sched(); add_wr(10, 16'h0030, 8'h33);
        run_check(1'b0, 16'd200, 4'b0001, ad, ex, 50, 20);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_seen", seen_mask, 4'b0000);
        check("rst_data", last_data, 0);
        check("rst_cycles", cycles, 0);
        @(negedge ph2);
        clear_sched();
        run_check(1'b0, 16'd30, 4'b0001, ad, ex, 0, 0);
        check("clean_seen", seen_mask, 4'b0000);
        check("clean_data", last_data[7:0], 8'h00);
        check("clean_fail", fail_mask, 4'b0001);
        check("clean_cycles", cycles, 30);

        // Randomised runs with shared addresses and a small data alphabet
        for (int r = 0; r < 40; r++) begin
            for (int j = 0; j < 3; j++) pool[j] = AW'(16'h0200 + $urandom_range(0, 15));
            for (int j = 0; j < 4; j++) vals[j] = DW'($urandom);
            for (int i = 0; i < NCH; i++) begin
                ad[i*AW +: AW] = pool[$urandom_range(0, 2)];
                ex[i*DW +: DW] = vals[$urandom_range(0, 3)];
            end
            clear_sched();
            for (int k = 1; k < 200; k++) begin
                if ($urandom_range(0, 9) < 3) begin
                    if ($urandom_range(0, 9) < 7) add_wr(k, pool[$urandom_range(0, 2)], vals[$urandom_range(0, 3)]);
                    else add_wr(k, AW'($urandom), DW'($urandom));
                end
            end
            run_check(1'($urandom), TW'($urandom_range(0, 150)), NCH'($urandom), ad, ex, 0, 0);
        end

        repeat (3) @(negedge ph2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Synthesizable, parametrised self-test monitor for the 6502 core; snoops the CPU memory write bus.
- Generalises the single-address "RAM[48] must equal 0xCE after N ns" regression check to NCHAN watched addresses, each with its own expected value.
- Has a cycle-count timeout and two compare modes, so suite tests can self-check on silicon and in simulation.
- Reports pass, per-channel fail, and per-channel seen flags.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- NCHAN, 4, number of watched address/expect channels.
- TMO_W, 16, width of the timeout/cycle counter.

Ports:
- ph2  in  1  clock; all state updates on the rising edge.
- resetb  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; latches configuration and begins a check.
- mode  in  1  0 = LAST (final value at timeout), 1 = FIRST (first write decides, early finish).
- timeout_cycles  in  TMO_W  run length in cycles; 0 is treated as 1.
- chk_en  in  NCHAN  per-channel enable.
- chk_addr  in  NCHAN*ADDR_W  watched addresses; channel i is at slice i.
- chk_expect  in  NCHAN*DATA_W  expected bytes.
- mem_we  in  1  CPU write strobe.
- mem_addr  in  ADDR_W  CPU write address.
- mem_wdata  in  DATA_W  CPU write data.
- busy  out  1  high in RUN and EVAL.
- done  out  1  high in DONE.
- pass  out  1  valid while done is high.
- fail_mask  out  NCHAN  per-channel failure.
- seen_mask  out  NCHAN  per-channel "write observed".
- last_data  out  NCHAN*DATA_W  captured bytes.
- cycles  out  TMO_W  RUN cycles elapsed.

Behaviour:
- Reset (resetb=0 at an edge): state IDLE. All outputs 0, including masks, last_data and cycles. Reset mid-RUN aborts the check with no result.
- States: IDLE, RUN, EVAL, DONE.
- IDLE or DONE, start=1 at edge E0:
  - latch mode, timeout, chk_en, chk_addr and chk_expect;
  - clear seen_mask, fail_mask, pass, last_data and cycles;
  - go to RUN.
- start is ignored in RUN and EVAL.
- RUN, each edge:
  - cycles increments.
  - For every enabled channel i where mem_we=1 and mem_addr equals the latched address i, capture the data:
    - LAST mode: last_data[i] is overwritten on every matching write; seen[i] is set.
    - FIRST mode: capture only while seen[i]=0, then set seen[i]; later writes are ignored.
  - Several channels may watch the same address; all of them capture the same write.
- RUN exit:
  - Timeout: the edge where cycles reaches T = max(timeout_cycles, 1). A write on that same edge is still captured.
  - FIRST mode only, early finish: the edge where every enabled channel is seen, counting the write on that edge. If all channels are disabled this happens on the first RUN edge.
  - Exit goes to EVAL.
- EVAL, one edge:
  - fail_mask[i] = en[i] & (~seen[i] | last_data[i] != expect[i]).
  - pass = (fail_mask == 0).
  - Go to DONE.
  - No capture in EVAL.
- DONE: results held stable; done=1 until start or reset.
- Latency, timeout path: start sampled at E0, RUN edges E1..ET, EVAL at ET+1. done, pass and fail_mask are visible after ET+1, with cycles = T.
- Counter saturates at all-ones; it cannot wrap because the exit condition fires first.

Decomposition:
- Package result_checker_pkg holds:
  - state enum {IDLE, RUN, EVAL, DONE};
  - mode constants MODE_LAST=0 and MODE_FIRST=1.
- Sub-module result_chan: one per channel, instantiated with a generate loop. It holds the latched address, expected value and enable, plus the capture register, seen flag and fail computation.
- The top level holds the FSM, counter and reductions (all-seen, pass).

Test Plan:
- Flag-test check: chan0 addr 0x0030, expect 0xCE, LAST mode, T=215, CPU writes 0xCE at cycle 10 → done after E216, pass=1, fail_mask=0000, cycles=215.
- Wrong value: same setup, write 0xCF → pass=0, fail_mask=0001, last_data[0]=0xCF.
- Overwrite semantics: writes 0x11 then 0xCE to 0x0030:
  - LAST mode → pass=1, last_data=0xCE;
  - FIRST mode, expect 0xCE → fail_mask=0001, last_data=0x11.
- FIRST mode early finish: chan0/1 at 0x0030/0x0031, expect 0xAA/0x55, T=1000, writes at cycles 5 and 9 → done after E10, cycles=9, pass=1.
- Missing write plus edge cases:
  - chan2 enabled, never written → fail_mask bit2=1, seen bit2=0;
  - timeout_cycles=0 → cycles=1;
  - chk_en=0000 in FIRST mode → done after E2, pass=1.
- Reset mid-RUN at cycle 50 → all outputs 0, IDLE. A following start runs a clean check with no stale seen or last_data; a start pulse sent during RUN is ignored.
